// File: rtl/dwt_pair_packer.sv
// Packs a raster sample stream into {odd, even} pairs for the 9/7 lifting unit.
// Odd-length lines are closed by whole-sample symmetric extension.
module dwt_pair_packer #(
  parameter int DataWidth = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  output logic                   err_o
);

  typedef enum logic {EVEN, ODD} state_t;

  state_t                 state_q, state_d;
  logic [DataWidth-1:0]   even_q, even_d;
  logic [DataWidth-1:0]   last_odd_q, last_odd_d;
  logic                   have_odd_q, have_odd_d;
  logic                   sof_q, sof_d;
  logic                   load;
  logic [2*DataWidth-1:0] pair;
  logic                   pair_sof, pair_eol;
  logic                   err_d;
  logic                   out_free, acc, odd_beat;

  assign out_free  = !m_valid_o | m_ready_i;
  assign s_ready_o = out_free;
  assign acc       = s_valid_i & out_free;
  // A sof beat in ODD restarts the frame and is handled as an even beat.
  assign odd_beat  = (state_q == ODD) & !s_sof_i;

  always_comb begin
    state_d    = state_q;
    even_d     = even_q;
    last_odd_d = last_odd_q;
    have_odd_d = have_odd_q;
    sof_d      = sof_q;
    load       = 1'b0;
    pair       = '0;
    pair_sof   = 1'b0;
    pair_eol   = 1'b0;
    err_d      = 1'b0;
    unique case (1'b1)
      acc & odd_beat: begin
        load       = 1'b1;
        pair       = {s_data_i, even_q};
        pair_sof   = sof_q;
        pair_eol   = s_eol_i;
        last_odd_d = s_data_i;
        have_odd_d = !s_eol_i;
        state_d    = EVEN;
      end
      acc & !odd_beat: begin
        err_d  = (state_q == ODD);
        even_d = s_data_i;
        sof_d  = s_sof_i;
        if (s_eol_i) begin
          load       = 1'b1;
          pair_sof   = s_sof_i;
          pair_eol   = 1'b1;
          have_odd_d = 1'b0;
          state_d    = EVEN;
          // Mirror only within the current line; a sof beat starts fresh.
          if (have_odd_q && !s_sof_i)
            pair = {last_odd_q, s_data_i};
          else
            pair = {s_data_i, s_data_i};
        end else begin
          state_d = ODD;
          if (s_sof_i)
            have_odd_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= EVEN;
      even_q     <= '0;
      last_odd_q <= '0;
      have_odd_q <= 1'b0;
      sof_q      <= 1'b0;
      m_valid_o  <= 1'b0;
      m_sof_o    <= 1'b0;
      m_eol_o    <= 1'b0;
      m_data_o   <= '0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      even_q     <= even_d;
      last_odd_q <= last_odd_d;
      have_odd_q <= have_odd_d;
      sof_q      <= sof_d;
      err_o      <= err_d;
      if (load) begin
        m_valid_o <= 1'b1;
        m_sof_o   <= pair_sof;
        m_eol_o   <= pair_eol;
        m_data_o  <= pair;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dwt_pair_packer.sv
// Directed bench for dwt_pair_packer: line-level reference model plus
// literal expectations on the emitted pair log.
module tb_dwt_pair_packer;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        e;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        s_ready_o;
  logic        s_valid_i;
  logic        s_sof_i;
  logic        s_eol_i;
  logic [15:0] s_data_i;
  logic        m_ready_i;
  logic        m_valid_o;
  logic        m_sof_o;
  logic        m_eol_o;
  logic [31:0] m_data_o;
  logic        err_o;

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    rnd_ready = 1'b0;
  pair_t expq[$];
  pair_t logq[$];
  logic [15:0] line_q[$];
  bit    line_sof = 1'b0;
  bit    hold_v = 1'b0;
  pair_t hold_p;
  bit    err_pend = 1'b0;
  int    err_seen = 0;

  dwt_pair_packer #(.DataWidth(16)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .s_ready_o(s_ready_o),
    .s_valid_i(s_valid_i),
    .s_sof_i  (s_sof_i),
    .s_eol_i  (s_eol_i),
    .s_data_i (s_data_i),
    .m_ready_i(m_ready_i),
    .m_valid_o(m_valid_o),
    .m_sof_o  (m_sof_o),
    .m_eol_o  (m_eol_o),
    .m_data_o (m_data_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pair_t got(input int i);
    if (i < logq.size()) return logq[i];
    return '0;
  endfunction

  function automatic pair_t mk(input int odd, input int even,
                               input bit s, input bit e);
    logic [15:0] o16, e16;
    o16 = 16'(odd);
    e16 = 16'(even);
    return {o16, e16, s, e};
  endfunction

  // Reference model: keeps the samples of the current line and derives
  // each pair from its position in the line.
  always @(negedge clk) begin
    pair_t a, p;
    int n;
    if (rst_i) begin
      expq.delete();
      line_q.delete();
      line_sof = 1'b0;
      hold_v   = 1'b0;
      err_pend = 1'b0;
    end else begin
      chk("err_o", 64'(err_o), 64'(err_pend));
      if (err_o) err_seen++;
      chk("s_ready", 64'(s_ready_o), 64'(!m_valid_o | m_ready_i));
      a = {m_data_o, m_sof_o, m_eol_o};
      if (hold_v) chk("stable", 64'(a), 64'(hold_p));
      hold_v = m_valid_o & !m_ready_i;
      hold_p = a;
      if (m_valid_o && m_ready_i) begin
        logq.push_back(a);
        if (expq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pair: got %h expected none", a);
        end else begin
          p = expq.pop_front();
          chk("pair", 64'(a), 64'(p));
        end
      end
      err_pend = 1'b0;
      if (s_valid_i && s_ready_o) begin
        if (s_sof_i) begin
          if (line_q.size() % 2 == 1) err_pend = 1'b1;
          line_q.delete();
          line_sof = 1'b1;
        end
        line_q.push_back(s_data_i);
        n = line_q.size();
        if (n % 2 == 0) begin
          expq.push_back({line_q[n-1], line_q[n-2],
                          (n == 2) && line_sof, s_eol_i});
        end else if (s_eol_i) begin
          expq.push_back({(n >= 3) ? line_q[n-2] : line_q[n-1],
                          line_q[n-1], (n == 1) && line_sof, 1'b1});
        end
        if (s_eol_i) begin
          line_q.delete();
          line_sof = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int d, input bit sof, input bit eol);
    bit ok;
    int n;
    s_valid_i = 1'b1;
    s_data_i  = 16'(d);
    s_sof_i   = sof;
    s_eol_i   = eol;
    n = 0;
    do begin
      @(negedge clk);
      ok = s_ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 64'(ok), 64'(1));
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, 64'(m_valid_o), 64'(0));
    chk({name, "_sof"}, 64'(m_sof_o), 64'(0));
    chk({name, "_eol"}, 64'(m_eol_o), 64'(0));
    chk({name, "_data"}, 64'(m_data_o), 64'(0));
    chk({name, "_err"}, 64'(err_o), 64'(0));
    chk({name, "_ready"}, 64'(s_ready_o), 64'(1));
  endtask

  initial begin
    int base, e0, n;
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    s_data_i  = '0;
    m_ready_i = 1'b1;
    idle(2);
    chk_zero("reset");
    rst_i = 1'b0;
    idle(1);

    base = logq.size();
    send(10, 1, 0);
    send(11, 0, 0);
    chk("lat_valid", 64'(m_valid_o), 64'(1));
    chk("lat_data", 64'(m_data_o), 64'(32'h000b_000a));
    chk("lat_sof", 64'(m_sof_o), 64'(1));
    send(12, 0, 0);
    send(13, 0, 1);
    idle(3);
    chk("even_count", 64'(logq.size() - base), 64'(2));
    chk("even_p0", 64'(got(base)), 64'(mk(11, 10, 1, 0)));
    chk("even_p1", 64'(got(base + 1)), 64'(mk(13, 12, 0, 1)));

    base = logq.size();
    for (int i = 1; i <= 5; i++) send(i, 0, i == 5);
    idle(3);
    chk("odd_count", 64'(logq.size() - base), 64'(3));
    chk("odd_p0", 64'(got(base)), 64'(mk(2, 1, 0, 0)));
    chk("odd_mirror", 64'(got(base + 2)), 64'(mk(4, 5, 0, 1)));

    base = logq.size();
    send(7, 1, 1);
    send(8, 0, 0);
    send(9, 0, 1);
    idle(3);
    chk("len1_count", 64'(logq.size() - base), 64'(2));
    chk("len1_p", 64'(got(base)), 64'(mk(7, 7, 1, 1)));
    chk("len1_next", 64'(got(base + 1)), 64'(mk(9, 8, 0, 1)));

    base = logq.size();
    rnd_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(100 + i, i == 0, i == 7);
    n = 0;
    while ((expq.size() != 0 || m_valid_o) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_drain", 64'(n < 300), 64'(1));
    rnd_ready = 1'b0;
    idle(2);
    chk("bp_count", 64'(logq.size() - base), 64'(4));
    chk("bp_p0", 64'(got(base)), 64'(mk(101, 100, 1, 0)));
    chk("bp_p3", 64'(got(base + 3)), 64'(mk(107, 106, 0, 1)));

    base = logq.size();
    e0 = err_seen;
    send(20, 0, 0);
    send(30, 1, 0);
    send(31, 0, 1);
    idle(3);
    chk("sof_err_pulses", 64'(err_seen - e0), 64'(1));
    chk("sof_count", 64'(logq.size() - base), 64'(1));
    chk("sof_pair", 64'(got(base)), 64'(mk(31, 30, 1, 1)));

    base = logq.size();
    send(40, 1, 0);
    rst_i = 1'b1;
    idle(1);
    chk_zero("midrst");
    rst_i = 1'b0;
    send(50, 1, 0);
    send(51, 0, 1);
    idle(3);
    chk("rst_count", 64'(logq.size() - base), 64'(1));
    chk("rst_pair", 64'(got(base)), 64'(mk(51, 50, 1, 1)));

    chk("final_drain", 64'(expq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
